omp_host_ctrl: RTL and testbench



---
 rtl/omp_host_pkg.sv | 31 +++
 rtl/omp_host_outbuf.sv | 51 +++++
 rtl/omp_host_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_omp_host_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/omp_host_pkg.sv
// Shared widths, state encoding and helpers for the OMP host sequencer.
package omp_host_pkg;

  localparam int unsigned Q_AW   = 15;
  localparam int unsigned X_AW   = 8;
  localparam int unsigned S_AW   = 7;
  localparam int unsigned WORD   = 32;
  localparam int unsigned BANK_W = 4;
  localparam int unsigned LEN_W  = S_AW + 1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD_Q,
    ST_LOAD_X,
    ST_START,
    ST_WAIT,
    ST_HDR,
    ST_RD_ADDR,
    ST_RD_CAP,
    ST_EMIT_S,
    ST_EMIT_V
  } state_t;

  // Saturate the core's support length to the readback memory depth.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [WORD-1:0] raw,
                                                 input int unsigned     lim);
    if (raw > WORD'(lim)) return LEN_W'(lim);
    return LEN_W'(raw);
  endfunction

endpackage

// File: rtl/omp_host_outbuf.sv
// Result-stream output register plus captured supp/V pair; holds data under backpressure.
module omp_host_outbuf
  import omp_host_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            hdr,
  input  logic [WORD-1:0] hdr_data,
  input  logic            cap,
  input  logic [WORD-1:0] supp_q,
  input  logic [WORD-1:0] v_q,
  input  logic            ldv,
  input  logic            last,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [WORD-1:0] out_data,
  output logic            out_last,
  output logic            accept_c
);

  logic [WORD-1:0] v_r;

  assign accept_c = out_valid & out_ready;

  // The output register doubles as the supp half of the pair; V waits in v_r.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      v_r       <= '0;
    end else if (hdr) begin
      out_valid <= 1'b1;
      out_data  <= hdr_data;
      out_last  <= last;
    end else if (cap) begin
      out_valid <= 1'b1;
      out_data  <= supp_q;
      out_last  <= 1'b0;
      v_r       <= v_q;
    end else if (ldv) begin
      out_valid <= 1'b1;
      out_data  <= v_r;
      out_last  <= last;
    end else if (accept_c) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/omp_host_ctrl.sv
// Host-side sequencer: loads Q/X into the OMP core, starts it, streams results back.
module omp_host_ctrl
  import omp_host_pkg::*;
#(
  parameter int unsigned Q_DEPTH = 32768,
  parameter int unsigned X_DEPTH = 100,
  parameter int unsigned S_MAX   = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  output logic            busy,
  output logic            done,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_data,
  output logic            out_last,
  output logic [Q_AW-1:0] q_address,
  output logic [WORD-1:0] q_data,
  output logic            q_we,
  output logic [X_AW-1:0] x_address,
  output logic [WORD-1:0] x_data,
  output logic            x_we,
  output logic            ap_start,
  input  logic            ap_done,
  input  logic            ap_idle,
  output logic [S_AW-1:0] v_address,
  input  logic [WORD-1:0] v_q,
  output logic [S_AW-1:0] supp_address,
  input  logic [WORD-1:0] supp_q,
  input  logic [WORD-1:0] supp_len
);

  state_t           state, state_next;
  logic [Q_AW-1:0]  cnt, cnt_next;
  logic [S_AW-1:0]  j, j_next;
  logic [LEN_W-1:0] len, len_next;
  logic [LEN_W-1:0] hdr_len;
  logic             pair_last;
  logic             done_set;
  logic             ob_hdr, ob_cap, ob_ldv, ob_last;
  logic             accept_c;

  assign hdr_len      = clamp_len(supp_len, S_MAX);
  assign pair_last    = (LEN_W'(j) == (len - LEN_W'(1)));
  assign v_address    = j;
  assign supp_address = j;

  // State, counters and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      j        <= '0;
      len      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ap_start <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      j        <= j_next;
      len      <= len_next;
      busy     <= (state_next != ST_IDLE);
      done     <= done_set;
      ap_start <= (state_next == ST_START);
    end
  end

  // Next-state logic; load strobes are combinational with the in_valid/in_ready handshake.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    j_next     = j;
    len_next   = len;
    in_ready   = 1'b0;
    q_we       = 1'b0;
    q_address  = '0;
    q_data     = '0;
    x_we       = 1'b0;
    x_address  = '0;
    x_data     = '0;
    ob_hdr     = 1'b0;
    ob_cap     = 1'b0;
    ob_ldv     = 1'b0;
    ob_last    = 1'b0;
    done_set   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) begin
          state_next = ST_LOAD_Q;
          cnt_next   = '0;
        end
      end
      ST_LOAD_Q: begin
        in_ready = ap_idle;
        if (in_valid && ap_idle) begin
          q_we      = 1'b1;
          q_address = {cnt[Q_AW-1:BANK_W], cnt[BANK_W-1:0]};
          q_data    = in_data;
          if (cnt == Q_AW'(Q_DEPTH - 1)) begin
            state_next = ST_LOAD_X;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + Q_AW'(1);
          end
        end
      end
      ST_LOAD_X: begin
        in_ready = ap_idle;
        if (in_valid && ap_idle) begin
          x_we      = 1'b1;
          x_address = cnt[X_AW-1:0];
          x_data    = in_data;
          if (cnt == Q_AW'(X_DEPTH - 1)) begin
            state_next = ST_START;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + Q_AW'(1);
          end
        end
      end
      ST_START: begin
        if (!ap_idle) state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (ap_done) begin
          len_next   = hdr_len;
          ob_hdr     = 1'b1;
          ob_last    = (hdr_len == '0);
          state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        if (accept_c) begin
          if (len == '0) begin
            done_set   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            j_next     = '0;
            state_next = ST_RD_ADDR;
          end
        end
      end
      ST_RD_ADDR: begin
        if (ap_idle) state_next = ST_RD_CAP;
      end
      ST_RD_CAP: begin
        ob_cap     = 1'b1;
        state_next = ST_EMIT_S;
      end
      ST_EMIT_S: begin
        if (accept_c) begin
          ob_ldv     = 1'b1;
          ob_last    = pair_last;
          state_next = ST_EMIT_V;
        end
      end
      ST_EMIT_V: begin
        if (accept_c) begin
          if (pair_last) begin
            done_set   = 1'b1;
            state_next = ST_IDLE;
          end else begin
            j_next     = j + S_AW'(1);
            state_next = ST_RD_ADDR;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  omp_host_outbuf u_outbuf (
    .clk       (clk),
    .rst       (rst),
    .hdr       (ob_hdr),
    .hdr_data  (WORD'(hdr_len)),
    .cap       (ob_cap),
    .supp_q    (supp_q),
    .v_q       (v_q),
    .ldv       (ob_ldv),
    .last      (ob_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .accept_c  (accept_c)
  );

endmodule

// File: tb/tb_omp_host_ctrl.sv
// Scoreboard bench for omp_host_ctrl with a behavioural OMP core model.
module tb_omp_host_ctrl;

  localparam int unsigned Q_DEPTH = 32;
  localparam int unsigned X_DEPTH = 4;
  localparam int unsigned S_MAX   = 128;
  localparam int          N_LOAD  = 36;

  typedef struct packed {
    logic        is_x;
    logic [31:0] addr;
    logic [31:0] data;
  } ld_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } out_t;

  logic        clk, rst, go, busy, done;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic [14:0] q_address;
  logic [31:0] q_data;
  logic        q_we;
  logic [7:0]  x_address;
  logic [31:0] x_data;
  logic        x_we;
  logic        ap_start, ap_done, ap_idle;
  logic [6:0]  v_address, supp_address;
  logic [31:0] v_q, supp_q, supp_len;

  logic [31:0] supp_mem [0:127];
  logic [31:0] v_mem    [0:127];
  logic        core_idle, idle_low, bp_en;
  logic [1:0]  cst;
  logic [3:0]  ccnt;

  ld_t  ld_q [$];
  out_t exp_q [$];
  ld_t  me;
  out_t mo;

  int   checks, errors;
  int   done_cnt, st_cnt, acc_cnt, run_no;
  logic hold_pend, hold_last, last_pend;
  logic [31:0] hold_data;

  omp_host_ctrl #(.Q_DEPTH(Q_DEPTH), .X_DEPTH(X_DEPTH), .S_MAX(S_MAX)) dut (
    .clk(clk), .rst(rst), .go(go), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .q_address(q_address), .q_data(q_data), .q_we(q_we),
    .x_address(x_address), .x_data(x_data), .x_we(x_we),
    .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .v_address(v_address), .v_q(v_q),
    .supp_address(supp_address), .supp_q(supp_q), .supp_len(supp_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ap_idle = core_idle & ~idle_low;

  // Core model: synchronous readback, drops idle 2 cycles after ap_start, done later.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_idle <= 1'b1;
      ap_done   <= 1'b0;
      cst       <= 2'd0;
      ccnt      <= 4'd0;
      supp_q    <= '0;
      v_q       <= '0;
    end else begin
      supp_q  <= supp_mem[supp_address];
      v_q     <= v_mem[v_address];
      ap_done <= 1'b0;
      case (cst)
        2'd0: if (ap_start) cst <= 2'd1;
        2'd1: begin core_idle <= 1'b0; cst <= 2'd2; ccnt <= 4'd5; end
        default: begin
          if (ccnt == 4'd0) begin
            core_idle <= 1'b1;
            ap_done   <= 1'b1;
            cst       <= 2'd0;
          end else begin
            ccnt <= ccnt - 4'd1;
          end
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},      32'(busy),         0);
    chk({tag, "_done"},      32'(done),         0);
    chk({tag, "_in_ready"},  32'(in_ready),     0);
    chk({tag, "_out_valid"}, 32'(out_valid),    0);
    chk({tag, "_out_data"},  out_data,          0);
    chk({tag, "_out_last"},  32'(out_last),     0);
    chk({tag, "_q_addr"},    32'(q_address),    0);
    chk({tag, "_q_data"},    q_data,            0);
    chk({tag, "_q_we"},      32'(q_we),         0);
    chk({tag, "_x_addr"},    32'(x_address),    0);
    chk({tag, "_x_data"},    x_data,            0);
    chk({tag, "_x_we"},      32'(x_we),         0);
    chk({tag, "_ap_start"},  32'(ap_start),     0);
    chk({tag, "_v_addr"},    32'(v_address),    0);
    chk({tag, "_s_addr"},    32'(supp_address), 0);
  endtask

  // Output randomly stalls only when backpressure is enabled.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: load writes, result words, hold stability, done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      hold_pend = 1'b0;
      last_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", 32'(out_valid), 1);
        chk("hold_data",  out_data,       hold_data);
        chk("hold_last",  32'(out_last),  32'(hold_last));
      end
      if (last_pend || done) chk("done_pulse", 32'(done), 32'(last_pend));
      if (done) done_cnt++;
      if (ap_start) st_cnt++;
      last_pend = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", 32'(exp_q.size()), 1);
        end else begin
          mo = exp_q.pop_front();
          chk("out_data", out_data,      mo.data);
          chk("out_last", 32'(out_last), 32'(mo.last));
          acc_cnt++;
          last_pend = out_last;
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      hold_last = out_last;
      if (q_we || x_we) begin
        if (ld_q.size() == 0) begin
          chk("spurious_we", 32'(ld_q.size()), 1);
        end else begin
          me = ld_q.pop_front();
          chk("ld_kind", 32'(x_we), 32'(me.is_x));
          chk("ld_addr", q_we ? 32'(q_address) : 32'(x_address), me.addr);
          chk("ld_data", q_we ? q_data : x_data, me.data);
        end
      end
    end
  end

  task automatic run(input int slen, input bit bp, input bit glitch, input bit rst_mid,
                     input bit junk);
    int   l, budget, d0;
    int unsigned base;
    ld_t  e;
    out_t o;
    base = 32'(run_no) * 1000;
    run_no++;
    for (int k = 0; k < 128; k++) begin
      supp_mem[k] = $urandom_range(0, 4095);
      v_mem[k]    = $urandom;
    end
    if (slen == 3) begin
      supp_mem[0] = 7;  v_mem[0] = 32'h3F80_0000;
      supp_mem[1] = 9;  v_mem[1] = 32'h4000_0000;
      supp_mem[2] = 2;  v_mem[2] = 32'h4040_0000;
    end
    supp_len = 32'(slen);
    l = (slen > 128) ? 128 : slen;
    acc_cnt = 0;
    st_cnt  = 0;
    d0      = done_cnt;
    o.data = 32'(l); o.last = (l == 0);
    exp_q.push_back(o);
    for (int k = 0; k < l; k++) begin
      o.data = supp_mem[k]; o.last = 1'b0;          exp_q.push_back(o);
      o.data = v_mem[k];    o.last = (k == l - 1);  exp_q.push_back(o);
    end

    // go together with word 0: in_valid is not accepted while IDLE
    go = 1'b1; in_valid = 1'b1; in_data = base;
    e.is_x = 1'b0; e.addr = 0; e.data = base;
    ld_q.push_back(e);
    @(negedge clk);
    chk("idle_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    go = 1'b0;
    @(negedge clk);
    chk("go_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    for (int i = 1; i < N_LOAD; i++) begin
      in_data = base + 32'(i);
      e.is_x  = (i >= 32);
      e.addr  = (i >= 32) ? 32'(i - 32) : 32'(i);
      e.data  = base + 32'(i);
      ld_q.push_back(e);
      if (glitch && i == 5) begin
        idle_low = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk("glitch_ready", 32'(in_ready), 0);
          chk("glitch_we",    32'(q_we),     0);
          @(posedge clk); #1;
        end
        idle_low = 1'b0;
      end
      budget = 0;
      @(negedge clk);
      while (!in_ready && budget < 50) begin
        @(negedge clk);
        budget++;
      end
      if (!in_ready) chk("load_timeout", 32'(in_ready), 1);
      @(posedge clk); #1;
    end
    in_valid = junk;
    in_data  = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("start_rise", 32'(ap_start), 1);
    chk("load_q_empty", 32'(ld_q.size()), 0);

    if (rst_mid) begin
      budget = 0;
      while (!(acc_cnt >= 3 && out_valid) && budget < 2000) begin
        @(negedge clk);
        budget++;
      end
      chk("mid_emit_valid", 32'(out_valid), 1);
      chk("start_cycles", 32'(st_cnt), 3);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      chk_zero("rst_mid");
      exp_q.delete();
      ld_q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_done", 32'(done_cnt - d0), 0);
    end else begin
      budget = 0;
      while (done_cnt == d0 && budget < 4000) begin
        @(negedge clk);
        budget++;
      end
      chk("done_count", 32'(done_cnt - d0), 1);
      chk("busy_end", 32'(busy), 0);
      chk("stream_left", 32'(exp_q.size()), 0);
      chk("start_cycles", 32'(st_cnt), 3);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0; done_cnt = 0; st_cnt = 0; acc_cnt = 0; run_no = 0;
    rst = 1'b0; go = 1'b0; in_valid = 1'b1; in_data = 32'h1234_5678;
    supp_len = '0; idle_low = 1'b0; bp_en = 1'b0;
    #3;
    chk_zero("reset");
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run(3, 1'b0, 1'b1, 1'b0, 1'b0);
    bp_en = 1'b1;
    run(3, 1'b1, 1'b0, 1'b0, 1'b1);
    bp_en = 1'b0;
    run(0, 1'b0, 1'b0, 1'b0, 1'b0);
    run(200, 1'b0, 1'b0, 1'b0, 1'b0);
    run(3, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
